// File: rtl/status_handshake_tx_if.sv
// Bundle for the FPGA->Pico status link: local valid/ready strobe plus the
// board-side nibble, REQ and asynchronous ACK.
interface status_handshake_tx_if #(
  parameter int DATA_WIDTH = 4
) ();
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  tx_done;
  logic                  tx_timeout;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  req_out;
  logic                  ack_in;

  // Driven by the filter FSM / board model.
  modport master (
    output tx_valid, tx_data, ack_in,
    input  tx_ready, tx_done, tx_timeout, data_out, req_out
  );

  // The transmitter itself.
  modport slave (
    input  tx_valid, tx_data, ack_in,
    output tx_ready, tx_done, tx_timeout, data_out, req_out
  );
endinterface

// File: rtl/status_handshake_tx.sv
// Four-phase REQ/ACK transmitter: sends one status nibble per transfer to the
// Pico, with setup delay, ACK synchronizer and per-state timeout recovery.
module status_handshake_tx #(
  parameter int DATA_WIDTH     = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 25_000,
  parameter int SYNC_STAGES    = 2
) (
  input logic                  clk,
  input logic                  reset,
  status_handshake_tx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_ACK,
    S_WAIT_REL,
    S_RECOVER
  } state_t;

  state_t                  r_state;
  logic [TW-1:0]           r_timer;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_req;
  logic                    r_done;
  logic                    r_timeout;

  logic w_ack_sync;
  logic w_ready;
  logic w_to_hit;

  assign w_ack_sync = r_sync[SYNC_STAGES-1];
  assign w_ready    = (r_state == S_IDLE) && !w_ack_sync;
  assign w_to_hit   = (r_timer == TO_LAST);

  assign bus.tx_ready   = w_ready;
  assign bus.tx_done    = r_done;
  assign bus.tx_timeout = r_timeout;
  assign bus.data_out   = r_data;
  assign bus.req_out    = r_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_sync    <= '0;
      r_data    <= '0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.ack_in};
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      // Saturating count; every transition below overrides it with a clear.
      if (r_state != S_IDLE && r_timer != TIMER_SAT) begin
        r_timer <= r_timer + TW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.tx_valid && w_ready) begin
            r_data  <= bus.tx_data;
            r_timer <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          // REQ rises SETUP_CYCLES+1 edges after the accept edge.
          if (r_timer == SETUP_LAST) begin
            r_req   <= 1'b1;
            r_timer <= '0;
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (w_ack_sync) begin
            r_req   <= 1'b0;
            r_timer <= '0;
            r_state <= S_WAIT_REL;
          end else if (w_to_hit) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_RECOVER;
          end
        end
        S_WAIT_REL: begin
          if (!w_ack_sync) begin
            r_done  <= 1'b1;
            r_timer <= '0;
            r_state <= S_IDLE;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (!w_ack_sync || w_to_hit) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_handshake_tx.sv
// Bench for status_handshake_tx: deadline-based transfer model checked every
// cycle, a Pico responder, and directed scenarios with literal timing checks.
module tb_status_handshake_tx;

  localparam int DW    = 4;
  localparam int SETUP = 2;
  localparam int TO    = 20;
  localparam int SYNC  = 2;
  localparam int LIMIT = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  status_handshake_tx_if #(.DATA_WIDTH(DW)) bus ();

  status_handshake_tx #(
    .DATA_WIDTH(DW),
    .SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- transfer model: phases with absolute-cycle deadlines
  typedef enum {M_IDLE, M_SETUP, M_ACK, M_REL, M_REC} mphase_t;
  mphase_t m_ph = M_IDLE;
  int cyc = 0;
  int m_evt = 0;
  logic m_req = 1'b0, m_done = 1'b0, m_to = 1'b0, m_on = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic m_hist [SYNC];   // ack_in as sampled on the last SYNC edges

  always @(posedge clk) begin
    logic seen;
    cyc++;
    seen = m_hist[SYNC-1];
    m_done = 1'b0;
    m_to = 1'b0;
    if (reset) begin
      m_on = 1'b1;
      m_ph = M_IDLE;
      m_req = 1'b0;
      m_data = '0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    end else begin
      case (m_ph)
        M_IDLE:  if (bus.tx_valid && !seen) begin
                   m_data = bus.tx_data; m_ph = M_SETUP; m_evt = cyc + SETUP + 1;
                 end
        M_SETUP: if (cyc == m_evt) begin m_req = 1'b1; m_ph = M_ACK; m_evt = cyc + TO; end
        M_ACK:   if (seen) begin m_req = 1'b0; m_ph = M_REL; m_evt = cyc + TO; end
                 else if (cyc == m_evt) begin
                   m_req = 1'b0; m_to = 1'b1; m_ph = M_REC; m_evt = cyc + TO;
                 end
        M_REL:   if (!seen) begin m_done = 1'b1; m_ph = M_IDLE; end
                 else if (cyc == m_evt) begin m_to = 1'b1; m_ph = M_REC; m_evt = cyc + TO; end
        M_REC:   if (!seen || cyc == m_evt) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = bus.ack_in;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("tx_ready",   32'(bus.tx_ready),   32'((m_ph == M_IDLE) && !m_hist[SYNC-1]));
      check("tx_done",    32'(bus.tx_done),    32'(m_done));
      check("tx_timeout", 32'(bus.tx_timeout), 32'(m_to));
      check("req_out",    32'(bus.req_out),    32'(m_req));
      check("data_out",   32'(bus.data_out),   32'(m_data));
    end
  end

  // ---------------- event monitor
  bit prev_req = 1'b0;
  int t_rise = 0, t_fall = 0, done_cnt = 0, to_cnt = 0, last_done = 0;

  always @(posedge clk) begin
    #1;
    if (bus.req_out === 1'b1 && !prev_req) t_rise = cyc;
    if (bus.req_out === 1'b0 && prev_req) t_fall = cyc;
    prev_req = (bus.req_out === 1'b1);
    if (bus.tx_done === 1'b1) begin done_cnt++; last_done = cyc; end
    if (bus.tx_timeout === 1'b1) to_cnt++;
  end

  // ---------------- Pico responder: 0 silent, 1 normal, 2 manual
  int pico_mode = 0;
  int ack_dly = 3, rel_dly = 3, pcnt = 0, t_ack_rise = 0;
  logic man_ack = 1'b0;
  logic [DW-1:0] rx_q [$];

  always @(negedge clk) begin
    #2;
    case (pico_mode)
      1: begin
        if (bus.ack_in !== 1'b1) begin
          if (bus.req_out === 1'b1) begin
            pcnt++;
            if (pcnt >= ack_dly) begin
              bus.ack_in = 1'b1; rx_q.push_back(bus.data_out); t_ack_rise = cyc; pcnt = 0;
            end
          end else begin
            bus.ack_in = 1'b0; pcnt = 0;
          end
        end else begin
          if (bus.req_out === 1'b0) begin
            pcnt++;
            if (pcnt >= rel_dly) begin bus.ack_in = 1'b0; pcnt = 0; end
          end else pcnt = 0;
        end
      end
      2: begin
        if (man_ack && bus.ack_in !== 1'b1) t_ack_rise = cyc;
        bus.ack_in = man_ack;
        pcnt = 0;
      end
      default: begin bus.ack_in = 1'b0; pcnt = 0; end
    endcase
  end

  // ---------------- stimulus helpers (called at a negedge)
  function automatic bit cond(input int what, input int tgt);
    case (what)
      0: return bus.req_out === 1'b1;
      1: return bus.req_out === 1'b0;
      2: return bus.tx_ready === 1'b1;
      3: return done_cnt >= tgt;
      4: return to_cnt >= tgt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int what, input int tgt, input string nm);
    int k = 0;
    while (!cond(what, tgt) && k < LIMIT) begin @(negedge clk); k++; end
    if (k >= LIMIT) check({nm, "_wait_expired"}, 32'(k), 32'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] nib, input bit keep, output int t_acc);
    int k = 0;
    bus.tx_data = nib;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && k < LIMIT) begin @(negedge clk); k++; end
    if (k >= LIMIT) check("accept_wait_expired", 32'(k), 32'(0));
    @(negedge clk);
    t_acc = cyc;
    if (!keep) bus.tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ta, d0, o0, c0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_req",   32'(bus.req_out),  32'd0);
    check("rst_data",  32'(bus.data_out), 32'd0);

    // 1: nominal transfer
    pico_mode = 1; ack_dly = 3; rel_dly = 3; rx_q.delete();
    d0 = done_cnt; o0 = to_cnt;
    send(4'hA, 1'b0, ta);
    wait_for(0, 0, "t1_req_hi");
    check("t1_setup_edges", 32'(t_rise - ta), 32'd3);
    check("t1_data", 32'(bus.data_out), 32'hA);
    wait_for(1, 0, "t1_req_lo");
    check("t1_fall_after_ack", 32'(t_fall - t_ack_rise), 32'd3);
    wait_for(3, d0 + 1, "t1_done");
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_no_timeout", 32'(to_cnt - o0), 32'd0);
    check("t1_rx_cnt", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t1_rx_val", 32'(rx_q[0]), 32'hA);
    wait_for(2, 0, "t1_idle");

    // 2: no ack -> timeout in WAIT_ACK
    pico_mode = 0; d0 = done_cnt; o0 = to_cnt;
    send(4'h5, 1'b0, ta);
    wait_for(0, 0, "t2_req_hi");
    wait_for(1, 0, "t2_req_lo");
    check("t2_req_width", 32'(t_fall - t_rise), 32'd20);
    wait_for(2, 0, "t2_ready");
    check("t2_ready_edge", 32'(cyc - t_fall), 32'd1);
    check("t2_timeout_cnt", 32'(to_cnt - o0), 32'd1);
    check("t2_no_done", 32'(done_cnt - d0), 32'd0);
    check("t2_data_hold", 32'(bus.data_out), 32'h5);

    // 3: stuck ack -> timeout in WAIT_REL, then release during RECOVER
    pico_mode = 2; man_ack = 1'b0; d0 = done_cnt; o0 = to_cnt;
    send(4'hC, 1'b0, ta);
    wait_for(0, 0, "t3_req_hi");
    tick(2);
    man_ack = 1'b1;
    wait_for(1, 0, "t3_req_lo");
    wait_for(4, o0 + 1, "t3_timeout");
    bus.tx_data = 4'hF;
    bus.tx_valid = 1'b1;
    repeat (3) begin
      tick(1);
      check("t3_ready_blocked", 32'(bus.tx_ready), 32'd0);
    end
    bus.tx_valid = 1'b0;
    man_ack = 1'b0;
    c0 = cyc;
    wait_for(2, 0, "t3_ready");
    check("t3_ready_latency", 32'(cyc - c0), 32'd3);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    check("t3_data_kept", 32'(bus.data_out), 32'hC);

    // 4: ack reaches the FSM on the same edge the timeout would fire
    d0 = done_cnt; o0 = to_cnt;
    send(4'h3, 1'b0, ta);
    wait_for(0, 0, "t4_req_hi");
    tick(TO - 3);
    man_ack = 1'b1;
    wait_for(1, 0, "t4_req_lo");
    check("t4_req_width", 32'(t_fall - t_rise), 32'd20);
    tick(1);
    check("t4_no_timeout", 32'(to_cnt - o0), 32'd0);
    man_ack = 1'b0;
    wait_for(3, d0 + 1, "t4_done");
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t4_no_timeout_end", 32'(to_cnt - o0), 32'd0);
    wait_for(2, 0, "t4_idle");

    // 5: reset in WAIT_ACK
    pico_mode = 0; d0 = done_cnt; o0 = to_cnt;
    send(4'h7, 1'b0, ta);
    wait_for(0, 0, "t5_req_hi");
    reset = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 4'h9;
    tick(1);
    check("t5_req_cleared", 32'(bus.req_out), 32'd0);
    check("t5_data_cleared", 32'(bus.data_out), 32'd0);
    tick(1);
    reset = 1'b0;
    bus.tx_valid = 1'b0;
    tick(2);
    check("t5_data_still0", 32'(bus.data_out), 32'd0);
    check("t5_no_pulses", 32'((done_cnt - d0) + (to_cnt - o0)), 32'd0);

    // 6: burst 1,2,3,4 with tx_valid held
    pico_mode = 1; ack_dly = 1; rel_dly = 1; rx_q.delete();
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i), (i < 4), ta);
      if (i > 1) check("t6_back_to_back", 32'(ta - last_done), 32'd1);
    end
    wait_for(3, d0 + 4, "t6_done");
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd4);
    check("t6_rx_cnt", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      check("t6_rx_order", 32'(rx_q[i]), 32'(i + 1));

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
